// File: rtl/target_scheduler.sv
// Frame-level colour target scheduler: picks one enabled colour per frame by round-robin,
// accumulates its pixel count and bounding box, and presents the result over valid/ready.
module target_scheduler #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int CNT_W      = 17,
  parameter int MIN_PIXELS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [4:0]       color_mask,
  input  logic             pixel_valid,
  input  logic             pixel_sof,
  input  logic             pixel_eof,
  input  logic [4:0]       match,
  output logic [2:0]       active_color,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [2:0]       result_color,
  output logic             result_found,
  output logic [CNT_W-1:0] result_count,
  output logic [X_W-1:0]   min_x,
  output logic [X_W-1:0]   max_x,
  output logic [Y_W-1:0]   min_y,
  output logic [Y_W-1:0]   max_y,
  output logic             overrun
);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  // Next enabled colour strictly after cur (wrapping over 5 colours); cur itself if none.
  function automatic logic [2:0] f_next(input logic [4:0] mask, input logic [2:0] cur);
    logic [3:0] sum;
    logic [2:0] idx;
    f_next = cur;
    for (int k = 4; k >= 1; k--) begin
      sum = {1'b0, cur} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (mask[idx]) f_next = idx;
    end
  endfunction

  state_t           r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [X_W-1:0]   r_min_x;
  logic [X_W-1:0]   r_max_x;
  logic [Y_W-1:0]   r_min_y;
  logic [Y_W-1:0]   r_max_y;

  logic [X_W-1:0]   w_cur_x;
  logic [Y_W-1:0]   w_cur_y;
  logic             w_proc;
  logic             w_end;
  logic [2:0]       w_entry_color;
  logic [2:0]       w_color;
  logic [2:0]       w_next_color;
  logic             w_hit;
  logic [CNT_W-1:0] w_base_cnt;
  logic [X_W-1:0]   w_base_min_x;
  logic [X_W-1:0]   w_base_max_x;
  logic [Y_W-1:0]   w_base_min_y;
  logic [Y_W-1:0]   w_base_max_y;
  logic [CNT_W-1:0] w_acc_cnt;
  logic [X_W-1:0]   w_acc_min_x;
  logic [X_W-1:0]   w_acc_max_x;
  logic [Y_W-1:0]   w_acc_min_y;
  logic [Y_W-1:0]   w_acc_max_y;
  logic             w_found;
  logic             w_load_ok;

  // Coordinates of the pixel on the bus this cycle; sof pins it to the origin.
  assign w_cur_x = pixel_sof ? '0 : r_x;
  assign w_cur_y = pixel_sof ? '0 : r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (pixel_valid) begin
      if (w_cur_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_cur_y == Y_LAST) ? '0 : w_cur_y + 1'b1;
      end else begin
        r_x <= w_cur_x + 1'b1;
        r_y <= w_cur_y;
      end
    end
  end

  // A pixel is consumed either mid-frame or as the sof that starts a frame from idle.
  assign w_proc = enable & pixel_valid &
                  ((r_state == S_ACCUM) | ((|color_mask) & pixel_sof));
  assign w_end  = w_proc & pixel_eof;

  assign w_entry_color = color_mask[active_color] ? active_color
                                                  : f_next(color_mask, active_color);
  assign w_color       = (r_state == S_IDLE) ? w_entry_color : active_color;
  assign w_next_color  = f_next(color_mask, w_color);
  assign w_hit         = match[w_color];

  // Any sof (entry or mid-frame restart) accumulates on top of fresh initial values.
  assign w_base_cnt   = pixel_sof ? '0 : r_cnt;
  assign w_base_min_x = pixel_sof ? '1 : r_min_x;
  assign w_base_max_x = pixel_sof ? '0 : r_max_x;
  assign w_base_min_y = pixel_sof ? '1 : r_min_y;
  assign w_base_max_y = pixel_sof ? '0 : r_max_y;

  assign w_acc_cnt   = (w_hit && (w_base_cnt != CNT_MAX)) ? w_base_cnt + 1'b1 : w_base_cnt;
  assign w_acc_min_x = (w_hit && (w_cur_x < w_base_min_x)) ? w_cur_x : w_base_min_x;
  assign w_acc_max_x = (w_hit && (w_cur_x > w_base_max_x)) ? w_cur_x : w_base_max_x;
  assign w_acc_min_y = (w_hit && (w_cur_y < w_base_min_y)) ? w_cur_y : w_base_min_y;
  assign w_acc_max_y = (w_hit && (w_cur_y > w_base_max_y)) ? w_cur_y : w_base_max_y;

  assign w_found   = (w_acc_cnt >= MIN_CNT);
  assign w_load_ok = !result_valid || result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_min_x      <= '0;
      r_max_x      <= '0;
      r_min_y      <= '0;
      r_max_y      <= '0;
      active_color <= '0;
      result_valid <= 1'b0;
      result_color <= '0;
      result_found <= 1'b0;
      result_count <= '0;
      min_x        <= '0;
      max_x        <= '0;
      min_y        <= '0;
      max_y        <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (result_valid && result_ready) result_valid <= 1'b0;

      if (!enable) begin
        r_state <= S_IDLE;
      end else if (w_proc) begin
        if (w_end) begin
          r_state      <= S_IDLE;
          active_color <= w_next_color;
          if (w_load_ok) begin
            result_valid <= 1'b1;
            result_color <= w_color;
            result_found <= w_found;
            result_count <= w_acc_cnt;
            min_x        <= w_found ? w_acc_min_x : '0;
            max_x        <= w_found ? w_acc_max_x : '0;
            min_y        <= w_found ? w_acc_min_y : '0;
            max_y        <= w_found ? w_acc_max_y : '0;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          r_state      <= S_ACCUM;
          active_color <= w_color;
          r_cnt        <= w_acc_cnt;
          r_min_x      <= w_acc_min_x;
          r_max_x      <= w_acc_max_x;
          r_min_y      <= w_acc_min_y;
          r_max_y      <= w_acc_max_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_target_scheduler.sv
// Randomised bench for target_scheduler on a reduced 48x32 frame, checked against a
// frame-level reference model (per-frame pixel list, round-robin rule, pending result).
module tb_target_scheduler;
  localparam int W = 48;
  localparam int H = 32;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [4:0]  color_mask;
  logic        pixel_valid, pixel_sof, pixel_eof;
  logic [4:0]  match;
  logic        result_ready;
  logic [2:0]  active_color, result_color;
  logic        result_valid, result_found, overrun;
  logic [16:0] result_count;
  logic [8:0]  min_x, max_x;
  logic [7:0]  min_y, max_y;

  wire [55:0] res_bus = {result_valid, result_color, result_found, result_count,
                         min_x, max_x, min_y, max_y};

  target_scheduler #(.IMG_W(W), .IMG_H(H), .X_W(9), .Y_W(8), .CNT_W(17), .MIN_PIXELS(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .color_mask(color_mask),
    .pixel_valid(pixel_valid), .pixel_sof(pixel_sof), .pixel_eof(pixel_eof), .match(match),
    .active_color(active_color), .result_valid(result_valid), .result_ready(result_ready),
    .result_color(result_color), .result_found(result_found), .result_count(result_count),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  int   m_active;
  int   rx0[5], rx1[5], ry0[5], ry1[5];
  bit   noise;
  bit   live;
  bit   ready_at_eof;
  int   mask_change_at;
  logic [4:0] mask_after;
  logic pre_valid;
  int   e_color, e_count, e_minx, e_maxx, e_miny, e_maxy;
  bit   e_found;

  function automatic int next_col(logic [4:0] m, int cur);
    for (int k = 1; k < 5; k++)
      if (m[(cur + k) % 5]) return (cur + k) % 5;
    return cur;
  endfunction

  function automatic logic [4:0] gen_match(int x, int y);
    logic [4:0] m = '0;
    for (int c = 0; c < 5; c++)
      if ((x >= rx0[c] && x <= rx1[c] && y >= ry0[c] && y <= ry1[c]) ||
          (noise && $urandom_range(0, 15) == 0))
        m[c] = 1'b1;
    return m;
  endfunction

  function automatic logic [55:0] exp_bus();
    return {1'b1, 3'(e_color), e_found, 17'(e_count), 9'(e_minx), 9'(e_maxx),
            8'(e_miny), 8'(e_maxy)};
  endfunction

  task automatic clear_rects();
    for (int c = 0; c < 5; c++) begin rx0[c] = 1; rx1[c] = 0; ry0[c] = 1; ry1[c] = 0; end
  endtask

  task automatic random_rects();
    for (int c = 0; c < 5; c++) begin
      rx0[c] = $urandom_range(0, W - 1); rx1[c] = $urandom_range(rx0[c], W - 1);
      ry0[c] = $urandom_range(0, H - 1); ry1[c] = $urandom_range(ry0[c], H - 1);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_pix(input logic v, input logic s, input logic e, input logic [4:0] m);
    pixel_valid = v; pixel_sof = s; pixel_eof = e; match = m;
    step();
  endtask

  task automatic idle_inputs();
    pixel_valid = 1'b0; pixel_sof = 1'b0; pixel_eof = 1'b0; match = '0;
  endtask

  // Streams one frame (or its first abort_at pixels) and updates the model.
  task automatic run_frame(input int abort_at, input bit gaps);
    int ec, cnt, mnx, mxx, mny, mxy, x, y;
    logic [4:0] m;
    ec = m_active;
    if (live) begin
      if (!color_mask[ec]) ec = next_col(color_mask, ec);
      m_active = ec;
    end
    cnt = 0; mnx = 1 << 20; mxx = -1; mny = 1 << 20; mxy = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (i == abort_at) begin idle_inputs(); return; end
      if (i == mask_change_at) color_mask = mask_after;
      if (gaps)
        while ($urandom_range(0, 3) == 0)
          drive_pix(1'b0, 1'($urandom), 1'($urandom), 5'($urandom));
      x = i % W; y = i / W;
      m = gen_match(x, y);
      if (live && m[ec]) begin
        cnt++;
        if (x < mnx) mnx = x; if (x > mxx) mxx = x;
        if (y < mny) mny = y; if (y > mxy) mxy = y;
      end
      if (i == NPIX - 1) begin
        if (ready_at_eof) result_ready = 1'b1;
        pre_valid = result_valid;
      end
      drive_pix(1'b1, i == 0, i == NPIX - 1, m);
      if (i == 0) begin
        n_tests++;
        if (active_color !== 3'(ec)) begin
          n_fail++; $display("FAIL frame_active_color got=%0d want=%0d", active_color, ec);
        end
      end
      if (!live) begin
        n_tests++;
        if ({result_valid, overrun, active_color} !== {1'b0, 1'b0, 3'(m_active)}) begin
          n_fail++;
          $display("FAIL idle_quiet got v=%b ov=%b ac=%0d want v=0 ov=0 ac=%0d",
                   result_valid, overrun, active_color, m_active);
        end
      end
    end
    idle_inputs();
    if (live) begin
      e_color = ec; e_count = cnt; e_found = (cnt >= 64);
      e_minx = e_found ? mnx : 0; e_maxx = e_found ? mxx : 0;
      e_miny = e_found ? mny : 0; e_maxy = e_found ? mxy : 0;
      m_active = next_col(color_mask, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; color_mask = '0; result_ready = 1'b0;
    idle_inputs();
    repeat (3) step();
    n_tests++;
    if ({res_bus, active_color, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h ac=%0d ov=%b want all 0", res_bus, active_color, overrun);
    end
    rst = 1'b0; m_active = 0;
    step();
    n_tests++;
    if ({res_bus, active_color, overrun} !== '0) begin
      n_fail++; $display("FAIL post_reset_outputs got=%h want 0", res_bus);
    end
  endtask

  task automatic test_block();
    enable = 1'b1; color_mask = 5'b00001; result_ready = 1'b0; live = 1; noise = 0;
    clear_rects();
    rx0[0] = 20; rx1[0] = 39; ry0[0] = 10; ry1[0] = 19;
    run_frame(-1, 1);
    n_tests++;
    if (pre_valid !== 1'b0) begin n_fail++; $display("FAIL block_latency got valid=%b at eof want 0", pre_valid); end
    n_tests++;
    if (res_bus !== exp_bus()) begin n_fail++; $display("FAIL block_result got=%h want=%h", res_bus, exp_bus()); end
    n_tests++;
    if ({result_count, min_x, max_x, min_y, max_y} !== {17'd200, 9'd20, 9'd39, 8'd10, 8'd19}) begin
      n_fail++; $display("FAIL block_values got cnt=%0d bbox=%0d/%0d/%0d/%0d want 200 20/39/10/19",
                         result_count, min_x, max_x, min_y, max_y);
    end
    result_ready = 1'b1;
    step();
    n_tests++;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL block_transfer got valid=%b want 0", result_valid); end
  endtask

  task automatic test_round_robin();
    int seq[4] = '{0, 2, 4, 0};
    color_mask = 5'b10101; result_ready = 1'b1; live = 1; noise = 1;
    for (int f = 0; f < 4; f++) begin
      random_rects();
      run_frame(-1, 1);
      n_tests++;
      if (res_bus !== exp_bus()) begin n_fail++; $display("FAIL rr_result[%0d] got=%h want=%h", f, res_bus, exp_bus()); end
      n_tests++;
      if (result_color !== 3'(seq[f])) begin n_fail++; $display("FAIL rr_color[%0d] got=%0d want=%0d", f, result_color, seq[f]); end
      n_tests++;
      if (active_color !== 3'(m_active)) begin n_fail++; $display("FAIL rr_next_active[%0d] got=%0d want=%0d", f, active_color, m_active); end
      step();
    end
  endtask

  task automatic test_threshold();
    color_mask = 5'b00010; result_ready = 1'b1; live = 1; noise = 0;
    clear_rects();
    rx0[1] = 5; rx1[1] = 13; ry0[1] = 3; ry1[1] = 9;
    run_frame(-1, 1);
    n_tests++;
    if (res_bus !== exp_bus() || result_count !== 17'd63 || result_found !== 1'b0) begin
      n_fail++; $display("FAIL thresh_63 got=%h want=%h", res_bus, exp_bus());
    end
    step();
    rx0[1] = 40; rx1[1] = 47; ry0[1] = 24; ry1[1] = 31;
    run_frame(-1, 1);
    n_tests++;
    if (res_bus !== exp_bus() || result_found !== 1'b1 || max_x !== 9'd47 || max_y !== 8'd31) begin
      n_fail++; $display("FAIL thresh_64 got=%h want=%h", res_bus, exp_bus());
    end
    step();
  endtask

  task automatic test_overrun();
    logic [55:0] held;
    color_mask = 5'b00111; result_ready = 1'b0; live = 1; noise = 1;
    random_rects();
    run_frame(-1, 1);
    held = exp_bus();
    n_tests++;
    if (res_bus !== held || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first got=%h ov=%b want=%h ov=0", res_bus, overrun, held); end
    random_rects();
    run_frame(-1, 1);
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%b want 1", overrun); end
    n_tests++;
    if (res_bus !== held) begin n_fail++; $display("FAIL ovr_held got=%h want=%h", res_bus, held); end
    step();
    n_tests++;
    if (overrun !== 1'b0 || res_bus !== held) begin n_fail++; $display("FAIL ovr_one_cycle got ov=%b bus=%h want ov=0 bus=%h", overrun, res_bus, held); end
    random_rects();
    ready_at_eof = 1;
    run_frame(-1, 1);
    ready_at_eof = 0;
    n_tests++;
    if (res_bus !== exp_bus() || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_swap got=%h ov=%b want=%h ov=0", res_bus, overrun, exp_bus()); end
    step();
    n_tests++;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got valid=%b want 0", result_valid); end
  endtask

  task automatic test_sof_abort();
    int c0;
    color_mask = 5'b11000; result_ready = 1'b1; live = 1; noise = 1;
    random_rects();
    run_frame(1000, 1);
    c0 = m_active;
    repeat (3) step();
    n_tests++;
    if (result_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL abort_no_result got v=%b ov=%b want 0 0", result_valid, overrun); end
    random_rects();
    run_frame(-1, 1);
    n_tests++;
    if (res_bus !== exp_bus() || result_color !== 3'(c0)) begin
      n_fail++; $display("FAIL abort_restart got=%h want=%h color=%0d", res_bus, exp_bus(), c0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    color_mask = 5'b00110; result_ready = 1'b0; live = 1; noise = 1;
    random_rects();
    run_frame(-1, 1);
    run_frame(500, 1);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({res_bus, active_color, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_mid got=%h ac=%0d ov=%b want all 0", res_bus, active_color, overrun);
    end
    step();
    rst = 1'b0; m_active = 0; result_ready = 1'b1;
    step();
    random_rects();
    run_frame(-1, 1);
    n_tests++;
    if (res_bus !== exp_bus()) begin n_fail++; $display("FAIL reset_recover got=%h want=%h", res_bus, exp_bus()); end
    step();
  endtask

  task automatic test_idle();
    logic [55:0] held;
    live = 0; noise = 1; random_rects(); result_ready = 1'b0;
    enable = 1'b1; color_mask = 5'b00000;
    run_frame(-1, 1);
    enable = 1'b0; color_mask = 5'b11111;
    run_frame(-1, 1);
    live = 1; enable = 1'b1;
    run_frame(-1, 1);
    held = exp_bus();
    run_frame(700, 1);
    enable = 1'b0;
    repeat (4) step();
    n_tests++;
    if (res_bus !== held || overrun !== 1'b0) begin n_fail++; $display("FAIL enable_drop_held got=%h want=%h", res_bus, held); end
    enable = 1'b1; result_ready = 1'b1;
    step();
    n_tests++;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL enable_drop_transfer got valid=%b want 0", result_valid); end
    run_frame(-1, 1);
    n_tests++;
    if (res_bus !== exp_bus()) begin n_fail++; $display("FAIL enable_drop_resume got=%h want=%h", res_bus, exp_bus()); end
    step();
  endtask

  task automatic test_random();
    live = 1; enable = 1'b1; result_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      color_mask = 5'($urandom_range(1, 31));
      noise = 1'($urandom);
      random_rects();
      if ($urandom_range(0, 1) == 1) begin
        mask_change_at = $urandom_range(200, 1300);
        mask_after = 5'($urandom_range(1, 31));
      end
      run_frame(-1, 1);
      mask_change_at = -1;
      n_tests++;
      if (res_bus !== exp_bus()) begin n_fail++; $display("FAIL random[%0d] got=%h want=%h", f, res_bus, exp_bus()); end
      n_tests++;
      if (active_color !== 3'(m_active)) begin n_fail++; $display("FAIL random_active[%0d] got=%0d want=%0d", f, active_color, m_active); end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; color_mask = '0; result_ready = 1'b0;
    pixel_valid = 1'b0; pixel_sof = 1'b0; pixel_eof = 1'b0; match = '0;
    live = 0; noise = 0; ready_at_eof = 0; mask_change_at = -1; mask_after = '0;
    m_active = 0; pre_valid = 1'b0;
    clear_rects();
    test_reset();
    test_block();
    test_round_robin();
    test_threshold();
    test_overrun();
    test_sof_abort();
    test_reset_mid();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/target_scheduler.md
Name: target_scheduler

Overview:
- Frame-level controller behind the per-pixel colour classifier.
- Each frame it selects one target colour by round-robin over a software-enabled mask. It then accumulates that colour's pixel count and bounding box from the classifier's match flags.
- At end of frame it presents a result over a valid/ready handshake to the downstream tracking logic.
- This shares the single classifier datapath among five colour targets, one frame each.

Parameters:
- IMG_W, 320, active pixels per line.
- IMG_H, 240, active lines per frame.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- CNT_W, 17, match counter width (saturating).
- MIN_PIXELS, 64, minimum count for result_found.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scheduler run enable.
- color_mask  in  5  enabled colours, bit order {green,blue,purple,pink,orange}; index 0 = orange.
- pixel_valid  in  1  pixel strobe.
- pixel_sof  in  1  first pixel of frame; qualified by pixel_valid.
- pixel_eof  in  1  last pixel of frame; qualified by pixel_valid.
- match  in  5  classifier flags, same bit order as color_mask.
- active_color  out  3  colour index being accumulated.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts.
- result_color  out  3  colour index of result.
- result_found  out  1  count >= MIN_PIXELS.
- result_count  out  CNT_W  matching pixel count.
- min_x, max_x  out  X_W  bounding box x.
- min_y, max_y  out  Y_W  bounding box y.
- overrun  out  1  one-cycle pulse: result dropped.

Behaviour:
- Reset: all outputs 0, active_color=0, FSM IDLE, accumulators cleared.
- Coordinates:
  - x/y counters advance only on pixel_valid.
  - pixel_sof forces the current pixel to (0,0).
  - x wraps at IMG_W-1 to 0 and increments y; y wraps at IMG_H-1.
- FSM states:
  - IDLE -> ACCUM when enable=1, color_mask!=0, and pixel_valid&pixel_sof. The sof pixel itself is accumulated.
  - ACCUM: on pixel_valid with match[active_color]=1, increment count (saturating at 2^CNT_W-1) and update min/max x/y.
  - ACCUM -> IDLE on pixel_valid&pixel_eof. The eof pixel is included. A result is generated and active_color advances.
  - ACCUM, pixel_valid&pixel_sof without a prior eof: abandon the partial frame, clear accumulators, restart on the same colour. No result is generated.
  - enable deasserted in any state: return to IDLE, abandon the frame, keep any pending result.
- Colour selection:
  - At frame end, active_color advances to the next set bit of color_mask above the current index, wrapping.
  - If no other bit is set, it keeps the current index, provided that index is still enabled.
  - On entry from IDLE, if mask[active_color]=0, active_color first advances to the next enabled index.
  - Mask changes mid-frame do not abort the frame.
  - mask=0: remain IDLE, active_color unchanged.
- Accumulator init per frame: count=0, min=all-ones, max=0.
- Result load:
  - Latency: eof pixel at cycle N -> result registers and result_valid=1 at N+1.
  - result_found = count >= MIN_PIXELS.
  - If result_found=0, bbox outputs are 0; result_count still reports the true count.
- Handshake:
  - Result outputs are held stable while result_valid && !result_ready.
  - Transfer occurs when valid&ready; result_valid then drops next cycle unless a new load coincides.
  - New load while pending and result_ready=0: the new result is dropped, overrun=1 for one cycle, and round-robin still advances.
  - New load in the same cycle as result_ready=1: the old result transfers, the new one loads, and result_valid stays 1.
- Reset mid-frame: immediate clear, no result, no overrun.

Test Plan:
- mask=00001, 320x240 frame, orange block at x 100..119, y 50..59 (200 px) -> at eof+1: result_valid=1, color=0, found=1, count=200, bbox 100/119/50/59.
- mask=10101, four consecutive frames -> result_color sequence 0,2,4,0; active_color matches.
- Frame with 63 matching pixels, MIN_PIXELS=64 -> found=0, count=63, bbox all 0.
- result_ready held low across two frames -> first result held unchanged, second dropped, one overrun pulse. Then ready=1 on a load cycle -> transfer plus new load, result_valid stays 1.
- Cases with no result generated:
  - sof at pixel 5000 of a frame -> no result, and the next complete frame reports the same colour.
  - rst asserted mid-frame -> all outputs 0 within the reset cycle.
- mask=0 or enable=0 with frames streaming -> no results, active_color unchanged, no overrun.
